// File: rtl/register_writeback_queue.sv
// register_writeback_queue
//   A small FIFO that sits in front of the register file write port. It
//   decouples writeback producers from stalls on the write port and tracks
//   which registers still have a write outstanding.
//
//   Optional feature: define WB_FORWARD_EN to add a read-side forwarding
//   port. It reports whether a queued entry targets the read register and
//   returns the youngest such entry's data.
//
// Ports
//   clk, reset_asynchronous        clock, asynchronous active-high reset
//   inp_valid / out_ready          request handshake (accept on valid & ready)
//   inp_write_address0/_data       request destination and data
//   inp_stall                      holds the register file write port
//   out_write_enable/_address0/_data  register file write port (head entry)
//   out_pending[15:0]              per-register outstanding-write scoreboard
//   out_r15_drop_count[7:0]        saturating count of discarded R15 requests
//   inp_read_address0, out_fwd_hit0, out_fwd_data0   forwarding (WB_FORWARD_EN)
module register_writeback_queue #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_asynchronous,
   input  logic          inp_valid,
   output logic          out_ready,
   input  logic [3:0]    inp_write_address0,
   input  logic [W-1:0]  inp_write_data,
   input  logic          inp_stall,
   output logic          out_write_enable,
   output logic [3:0]    out_write_address0,
   output logic [W-1:0]  out_write_data,
   output logic [15:0]   out_pending,
   output logic [7:0]    out_r15_drop_count
`ifdef WB_FORWARD_EN
   ,
   input  logic [3:0]    inp_read_address0,
   output logic          out_fwd_hit0,
   output logic [W-1:0]  out_fwd_data0
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [3:0]       addr_q [DEPTH];
   logic [3:0]       addr_d [DEPTH];
   logic [W-1:0]     data_q [DEPTH];
   logic [W-1:0]     data_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       drop_q, drop_d;

   logic             accept, push, pop, drop_hit;
   logic [DEPTH-1:0] ent_vld;

   assign out_ready          = (count_q != CNT_W'(DEPTH));
   assign accept             = inp_valid & out_ready;
   // R15 belongs to the PC path: accepted but never queued.
   assign drop_hit           = accept & (inp_write_address0 == 4'hF);
   assign push               = accept & (inp_write_address0 != 4'hF);
   assign out_write_enable   = (count_q != '0) & ~inp_stall;
   assign pop                = out_write_enable;
   assign out_write_address0 = (count_q != '0) ? addr_q[head_q] : 4'h0;
   assign out_write_data     = (count_q != '0) ? data_q[head_q] : '0;
   assign out_r15_drop_count = drop_q;

   // A slot is live when its distance from the head is below the count.
   always_comb begin
      logic [PTR_W-1:0] off;
      ent_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off        = PTR_W'(i) - head_q;
         ent_vld[i] = (CNT_W'(off) < count_q);
      end
   end

   always_comb begin
      out_pending = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_vld[i]) out_pending[addr_q[i]] = 1'b1;
      out_pending[15] = 1'b0;
   end

`ifdef WB_FORWARD_EN
   // Walk oldest to youngest so the last match (youngest) wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      out_fwd_hit0  = 1'b0;
      out_fwd_data0 = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (addr_q[idx] == inp_read_address0)) begin
            out_fwd_hit0  = 1'b1;
            out_fwd_data0 = data_q[idx];
         end
      end
   end
`endif

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      drop_d  = drop_q;
      if (push) begin
         addr_d[tail_q] = inp_write_address0;
         data_d[tail_q] = inp_write_data;
         tail_d         = tail_q + 1'b1;
      end
      if (pop) head_d = head_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (drop_hit && (drop_q != 8'hFF)) drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset_asynchronous) begin
      if (reset_asynchronous) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         drop_q  <= drop_d;
      end
   end

   // Payload storage needs no reset: every read is qualified by the count.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_register_writeback_queue.sv
module tb_register_writeback_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        vld;
   logic        rdy;
   logic [3:0]  wa;
   logic [31:0] wd;
   logic        stall;
   logic        we;
   logic [3:0]  oa;
   logic [31:0] od;
   logic [15:0] pend;
   logic [7:0]  drop;
`ifdef WB_FORWARD_EN
   logic [3:0]  rd;
   logic        hit;
   logic [31:0] fd;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   register_writeback_queue #(.W(32), .DEPTH(4)) dut (
      .clk(clk), .reset_asynchronous(rst),
      .inp_valid(vld), .out_ready(rdy),
      .inp_write_address0(wa), .inp_write_data(wd), .inp_stall(stall),
      .out_write_enable(we), .out_write_address0(oa), .out_write_data(od),
      .out_pending(pend), .out_r15_drop_count(drop)
`ifdef WB_FORWARD_EN
      , .inp_read_address0(rd), .out_fwd_hit0(hit), .out_fwd_data0(fd)
`endif
   );

   typedef struct {
      logic        vld;
      logic [3:0]  a;
      logic [31:0] d;
      logic        stall;
      logic [3:0]  rd;
      logic        e_we;
      logic [3:0]  e_a;
      logic [31:0] e_d;
      logic        e_rdy;
      logic [15:0] e_pend;
      logic [7:0]  e_drop;
      logic        e_hit;
      logic [31:0] e_fd;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(logic v, logic [3:0] a, logic [31:0] d, logic s,
                               logic [3:0] r, logic ewe, logic [3:0] ea,
                               logic [31:0] ed, logic erdy, logic [15:0] ep,
                               logic [7:0] edr, logic eh, logic [31:0] ef);
      vec_t t;
      t.vld = v; t.a = a; t.d = d; t.stall = s; t.rd = r;
      t.e_we = ewe; t.e_a = ea; t.e_d = ed; t.e_rdy = erdy;
      t.e_pend = ep; t.e_drop = edr; t.e_hit = eh; t.e_fd = ef;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic ewe, input logic [3:0] ea,
                          input logic [31:0] ed, input logic erdy,
                          input logic [15:0] ep, input logic [7:0] edr,
                          input logic eh, input logic [31:0] ef);
      chk("we", idx, 32'(we), 32'(ewe));
      chk("waddr", idx, 32'(oa), 32'(ea));
      chk("wdata", idx, od, ed);
      chk("ready", idx, 32'(rdy), 32'(erdy));
      chk("pending", idx, 32'(pend), 32'(ep));
      chk("drop", idx, 32'(drop), 32'(edr));
`ifdef WB_FORWARD_EN
      chk("fwd_hit", idx, 32'(hit), 32'(eh));
      chk("fwd_data", idx, fd, ef);
`else
      if (eh !== 1'b0 && ef === 32'hx) $display("note: forwarding vector %0d", idx);
`endif
   endtask

   task automatic drive(input logic v, input logic [3:0] a, input logic [31:0] d,
                        input logic s, input logic [3:0] r);
      vld = v; wa = a; wd = d; stall = s;
`ifdef WB_FORWARD_EN
      rd = r;
`else
      if (r === 4'hx) $display("note: read address unknown");
`endif
   endtask

   initial begin
      // single write, R15 drop, fill under stall (5th push refused while popping)
      tv.push_back(mk(0, 0,  0,          0, 0, 0, 0, 0,          1, 16'h0000, 0, 0, 0));
      tv.push_back(mk(1, 3,  32'hA5A5A5A5,0, 0, 0, 0, 0,          1, 16'h0000, 0, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 1, 3, 32'hA5A5A5A5,1, 16'h0008, 0, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 0, 0, 0,          1, 16'h0000, 0, 0, 0));
      tv.push_back(mk(1, 15, 32'h11,     0, 0, 0, 0, 0,          1, 16'h0000, 0, 0, 0));
      tv.push_back(mk(1, 15, 32'h12,     0, 0, 0, 0, 0,          1, 16'h0000, 1, 0, 0));
      tv.push_back(mk(1, 15, 32'h13,     0, 0, 0, 0, 0,          1, 16'h0000, 2, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 0, 0, 0,          1, 16'h0000, 3, 0, 0));
      tv.push_back(mk(1, 1,  32'h101,    1, 0, 0, 0, 0,          1, 16'h0000, 3, 0, 0));
      tv.push_back(mk(1, 2,  32'h102,    1, 0, 0, 1, 32'h101,    1, 16'h0002, 3, 0, 0));
      tv.push_back(mk(1, 4,  32'h104,    1, 0, 0, 1, 32'h101,    1, 16'h0006, 3, 0, 0));
      tv.push_back(mk(1, 5,  32'h105,    1, 0, 0, 1, 32'h101,    1, 16'h0016, 3, 0, 0));
      tv.push_back(mk(1, 6,  32'h106,    1, 0, 0, 1, 32'h101,    0, 16'h0036, 3, 0, 0));
      tv.push_back(mk(1, 6,  32'h106,    0, 0, 1, 1, 32'h101,    0, 16'h0036, 3, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 1, 2, 32'h102,    1, 16'h0034, 3, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 1, 4, 32'h104,    1, 16'h0030, 3, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 1, 5, 32'h105,    1, 16'h0020, 3, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 0, 0, 0,          1, 16'h0000, 3, 0, 0));
      // scoreboard and forwarding: two writes to R7 under stall
      tv.push_back(mk(1, 7,  32'h1,      1, 7, 0, 0, 0,          1, 16'h0000, 3, 0, 0));
      tv.push_back(mk(1, 7,  32'h2,      1, 7, 0, 7, 32'h1,      1, 16'h0080, 3, 1, 32'h1));
      tv.push_back(mk(0, 0,  0,          1, 7, 0, 7, 32'h1,      1, 16'h0080, 3, 1, 32'h2));
      tv.push_back(mk(0, 0,  0,          0, 7, 1, 7, 32'h1,      1, 16'h0080, 3, 1, 32'h2));
      tv.push_back(mk(0, 0,  0,          0, 7, 1, 7, 32'h2,      1, 16'h0080, 3, 1, 32'h2));
      tv.push_back(mk(0, 0,  0,          0, 7, 0, 0, 0,          1, 16'h0000, 3, 0, 0));
      // count=2 then push+pop twice across the pointer wrap
      tv.push_back(mk(1, 8,  32'h208,    1, 0, 0, 0, 0,          1, 16'h0000, 3, 0, 0));
      tv.push_back(mk(1, 9,  32'h209,    1, 0, 0, 8, 32'h208,    1, 16'h0100, 3, 0, 0));
      tv.push_back(mk(1, 10, 32'h20A,    0, 0, 1, 8, 32'h208,    1, 16'h0300, 3, 0, 0));
      tv.push_back(mk(1, 11, 32'h20B,    0, 0, 1, 9, 32'h209,    1, 16'h0600, 3, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 1, 10,32'h20A,    1, 16'h0C00, 3, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 1, 11,32'h20B,    1, 16'h0800, 3, 0, 0));
      tv.push_back(mk(0, 0,  0,          0, 0, 0, 0, 0,          1, 16'h0000, 3, 0, 0));

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      #1;
      chk_all(-1, 0, 0, 0, 1, 16'h0, 8'h0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tv[i]) begin
         @(negedge clk);
         drive(tv[i].vld, tv[i].a, tv[i].d, tv[i].stall, tv[i].rd);
         #1;
         chk_all(i, tv[i].e_we, tv[i].e_a, tv[i].e_d, tv[i].e_rdy,
                 tv[i].e_pend, tv[i].e_drop, tv[i].e_hit, tv[i].e_fd);
      end

      // async reset between edges with three entries queued
      @(negedge clk); drive(1, 1, 32'h31, 1, 1);
      @(negedge clk); drive(1, 2, 32'h32, 1, 1);
      @(negedge clk); drive(1, 3, 32'h33, 1, 1);
      @(negedge clk); drive(0, 0, 0, 1, 1);
      #1;
      chk_all(100, 0, 1, 32'h31, 1, 16'h000E, 8'd3, 1, 32'h31);
      #2;
      rst = 1'b1;
      #1;
      chk_all(101, 0, 0, 0, 1, 16'h0, 8'd0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk_all(102 + c, 0, 0, 0, 1, 16'h0, 8'd0, 0, 0);
      end
      @(negedge clk); drive(1, 6, 32'h66, 0, 6);
      @(negedge clk); drive(0, 0, 0, 0, 6);
      #1;
      chk_all(105, 1, 6, 32'h66, 1, 16'h0040, 8'd0, 1, 32'h66);
      @(negedge clk);
      #1;
      chk_all(106, 0, 0, 0, 1, 16'h0, 8'd0, 0, 0);

      // drop counter saturates at 255
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         drive(1, 15, 32'(c), 0, 0);
      end
      @(negedge clk); drive(0, 0, 0, 0, 0);
      #1;
      chk_all(107, 0, 0, 0, 1, 16'h0, 8'd255, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
